branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences front-end redirects when EX resolves a control-flow instruction.
- Takes the resolved outcome and the computed target from EX, with the target produced by the branch target generator. Fetch always predicts not-taken.
- On a taken branch, JAL or JALR, the block:
  - issues one redirect to fetch using a valid/ready handshake;
  - flushes IF/ID wrong-path instructions until the redirect settles;
  - flags misaligned targets instead of redirecting.
- Sits between the EX stage and the PC/fetch unit.

Parameters:
- width_p, 32: PC and target width.
- flush_cycles_p, 1: extra cycles flush_o stays high after the redirect handshake. Legal range is 0..7.
- cnt_width_p, 16: width of the redirect performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  the EX stage holds a valid instruction this cycle.
- is_branch_i  in  1  the EX instruction is a conditional branch.
- is_jal_i  in  1  the EX instruction is JAL.
- is_jalr_i  in  1  the EX instruction is JALR.
- branch_taken_i  in  1  branch comparison result; only meaningful when is_branch_i is high.
- target_i  in  width_p  resolved target from the branch target generator.
- redirect_valid_o  out  1  a redirect is offered to fetch.
- redirect_pc_o  out  width_p  the PC to fetch next.
- redirect_ready_i  in  1  fetch accepts the redirect this cycle.
- flush_o  out  1  kill IF/ID contents and do not let them advance.
- misaligned_o  out  1  one-cycle pulse for a misaligned target exception.
- misaligned_addr_o  out  width_p  the offending target; held until the next misalignment.
- redirect_count_o  out  cnt_width_p  number of completed redirects.

Behaviour:
- Reset (reset_i high at a clock edge), effective the following cycle:
  - state goes to IDLE;
  - redirect_valid_o=0, redirect_pc_o=0, flush_o=0, misaligned_o=0, misaligned_addr_o=0, redirect_count_o=0.
- Reset has priority over every other event, including mid-PEND and mid-FLUSH. Any pending redirect is dropped.
- Resolve condition, sampled only in IDLE:
  - take = ex_valid_i & (is_jal_i | is_jalr_i | (is_branch_i & branch_taken_i)).
  - The is_* inputs are one-hot or zero. If more than one is set, JALR has priority, then JAL, then branch.
- misaligned = take & (target_i[1] != 0). Bit 0 is ignored.
- State IDLE: outputs are low.
  - take & !misaligned at edge N: register target_i into redirect_pc_o and go to PEND. In cycle N+1, redirect_valid_o=1 and flush_o=1.
  - take & misaligned at edge N: misaligned_o=1 for cycle N+1 only, misaligned_addr_o=target_i, state stays IDLE, no flush.
  - No take: stay in IDLE.
- State PEND: redirect_valid_o=1, flush_o=1, and redirect_pc_o stays stable until the handshake.
  - Handshake completes on an edge where redirect_valid_o & redirect_ready_i.
  - At that edge, redirect_count_o increments, wrapping mod 2^cnt_width_p.
  - Next state is FLUSH with a down-counter loaded to flush_cycles_p. If flush_cycles_p=0, go straight to IDLE.
  - ready low: remain in PEND indefinitely.
- State FLUSH: redirect_valid_o=0, flush_o=1.
  - The counter decrements each cycle. Return to IDLE on the edge where it reaches 1, so flush_o is high for exactly flush_cycles_p cycles after the handshake cycle.
- Outside IDLE, ex_valid_i and the other EX inputs are ignored. Those instructions are wrong-path and are killed by flush_o; they produce no redirect and no misaligned pulse.
- The earliest a new take can be accepted is the first IDLE cycle.
- redirect_ready_i is a don't-care outside PEND.
- Arithmetic: counter wraps. redirect_pc_o is exactly target_i; no addition is performed.
- Latency: resolve to redirect_valid_o is 1 cycle. The minimum resolve-to-IDLE time is 2+flush_cycles_p cycles.

Test Plan:
- Taken branch, target_i=0x0000_0100, ready held high, flush_cycles_p=1:
  - redirect_valid_o=1 with redirect_pc_o=0x100 for 1 cycle;
  - flush_o high for 2 cycles;
  - count goes 0→1, then the block returns to IDLE.
- JAL to 0x200 with ready low for 3 cycles:
  - redirect_valid_o and flush_o stay high;
  - redirect_pc_o=0x200 stays stable while target_i changes to 0x999 on cycles where ex_valid_i=1;
  - a single redirect is issued and count increments exactly once.
- Not-taken branch (is_branch_i=1, branch_taken_i=0) and ex_valid_i=0 with is_jal_i=1: no redirect_valid_o, no flush_o, count unchanged.
- JALR with target_i=0x0000_0102: misaligned_o pulses 1 cycle, misaligned_addr_o=0x102, no redirect, no flush.
- Second JAL arriving during PEND and during FLUSH is ignored. Assert reset_i during PEND: the next cycle shows all outputs 0 and state IDLE, and a new JAL is accepted normally afterwards.
- With cnt_width_p=4, complete 16 redirects: redirect_count_o wraps 15→0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: turns a resolved taken branch/JAL/JALR from EX
// into a single fetch redirect (valid/ready), holds flush until it settles, and flags misaligned targets.
module branch_redirect_ctrl #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned flush_cycles_p = 1,
    parameter int unsigned cnt_width_p    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   ex_valid_i,
    input  logic                   is_branch_i,
    input  logic                   is_jal_i,
    input  logic                   is_jalr_i,
    input  logic                   branch_taken_i,
    input  logic [width_p-1:0]     target_i,
    output logic                   redirect_valid_o,
    output logic [width_p-1:0]     redirect_pc_o,
    input  logic                   redirect_ready_i,
    output logic                   flush_o,
    output logic                   misaligned_o,
    output logic [width_p-1:0]     misaligned_addr_o,
    output logic [cnt_width_p-1:0] redirect_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       take, misaligned, accept, handshake;

    // Every is_* source produces the same redirect, so their priority has no visible effect.
    assign take       = ex_valid_i & (is_jalr_i | is_jal_i | (is_branch_i & branch_taken_i));
    assign misaligned = take & target_i[1];
    assign accept     = (state_q == IDLE) & take & ~misaligned;
    assign handshake  = (state_q == PEND) & redirect_ready_i;

    assign redirect_valid_o = (state_q == PEND);
    assign flush_o          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PEND;
            end
            PEND: begin
                if (redirect_ready_i) begin
                    flush_cnt_d = 3'(flush_cycles_p);
                    state_d     = (flush_cycles_p == 0) ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q <= 3'd1) state_d = IDLE;
                else                     flush_cnt_d = flush_cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q           <= IDLE;
            flush_cnt_q       <= '0;
            redirect_pc_o     <= '0;
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
            redirect_count_o  <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            misaligned_o <= (state_q == IDLE) & misaligned;
            if ((state_q == IDLE) & misaligned) misaligned_addr_o <= target_i;
            if (accept)                         redirect_pc_o     <= target_i;
            if (handshake)                      redirect_count_o  <= redirect_count_o + 1'b1;
        end
    end

endmodule
